consumer_request_port: RTL and testbench

Per-consumer front end that sits directly upstream of the round-robin scheduling kernel, one instance per consumer. It queues a consumer's PLM read/write requests in a small FIFO, packs the head entry onto the scheduler's `{addr, value, wr, valid}` request lane, and holds that request until the scheduler's `{value, valid}` response lane reports service. It then pops the entry and returns a registered one-cycle response to the consumer. It also counts arbitration wait cycles and flags protocol violations from the scheduler side.

---
 rtl/consumer_request_port.sv | 114 +++++++++++
 tb/tb_consumer_request_port.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/consumer_request_port.sv
// Per-consumer request front end: queues PLM requests, presents the head to the
// round-robin scheduler lane and returns a registered one-cycle response.
module consumer_request_port #(
  parameter int ADDR_WIDTH     = 4,
  parameter int VALUE_WIDTH    = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int WAIT_CNT_WIDTH = 8,
  localparam int REQ_WIDTH     = ADDR_WIDTH + VALUE_WIDTH + 2,
  localparam int RES_WIDTH     = VALUE_WIDTH + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_WIDTH-1:0]     in_addr,
  input  logic [VALUE_WIDTH-1:0]    in_value,
  input  logic                      in_wr,
  output logic [REQ_WIDTH-1:0]      sched_req,
  input  logic [RES_WIDTH-1:0]      sched_res,
  output logic                      rsp_valid,
  output logic [VALUE_WIDTH-1:0]    rsp_value,
  output logic                      rsp_wr,
  output logic                      busy,
  output logic [WAIT_CNT_WIDTH-1:0] wait_cycles,
  output logic                      protocol_err
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_WIDTH + VALUE_WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t                    state_q;
  logic [ENTRY_W-1:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]          rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      presented_q;
  logic                      rsp_valid_q, rsp_wr_q, protocol_err_q;
  logic [VALUE_WIDTH-1:0]    rsp_value_q;
  logic [WAIT_CNT_WIDTH-1:0] wait_q, wait_d;
  logic                      enq, service, stray_res;
  logic [ENTRY_W-1:0]        head;

  assign head      = mem_q[rd_ptr_q];
  assign in_ready  = ~reset & (count_q != FULL_CNT);
  assign enq       = in_valid & in_ready;
  assign service   = sched_res[0] & presented_q;
  assign stray_res = sched_res[0] & ~presented_q;

  // Valid is masked while a response arrives so the scheduler never re-issues the head.
  assign sched_req = (state_q == REQ) ? {head, ~sched_res[0]} : '0;

  assign rsp_valid    = rsp_valid_q;
  assign rsp_value    = rsp_value_q;
  assign rsp_wr       = rsp_wr_q;
  assign busy         = (count_q != '0);
  assign wait_cycles  = wait_q;
  assign protocol_err = protocol_err_q;

  always_comb begin
    count_d = count_q;
    if (enq && !service) begin
      count_d = count_q + ONE_CNT;
    end else if (!enq && service) begin
      count_d = count_q - ONE_CNT;
    end
    wait_d = wait_q;
    if (service || state_q == IDLE) begin
      wait_d = '0;
    end else if (wait_q != '1) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      presented_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_value_q    <= '0;
      rsp_wr_q       <= 1'b0;
      wait_q         <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      presented_q <= sched_req[0];
      count_q     <= count_d;
      wait_q      <= wait_d;
      rsp_valid_q <= service;
      if (enq) begin
        mem_q[wr_ptr_q] <= {in_addr, in_value, in_wr};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (service) begin
        rd_ptr_q    <= rd_ptr_q + 1'b1;
        rsp_value_q <= sched_res[RES_WIDTH-1:1];
        rsp_wr_q    <= head[0];
      end
      if (stray_res) protocol_err_q <= 1'b1;
      case (state_q)
        IDLE: if (enq) state_q <= REQ;
        REQ:  if (service && !enq && count_q == ONE_CNT) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_consumer_request_port.sv
// Directed bench for consumer_request_port: a queue-based reference model is
// compared every cycle, plus hand-computed literal checks at key points.
module tb_consumer_request_port;

  localparam int AW = 4;
  localparam int VW = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_addr = '0;
  logic [VW-1:0] in_value = '0;
  logic          in_wr = 1'b0;
  logic [AW+VW+1:0] sched_req;
  logic [VW:0]   sched_res = '0;
  logic          rsp_valid;
  logic [VW-1:0] rsp_value;
  logic          rsp_wr;
  logic          busy;
  logic [7:0]    wait_cycles;
  logic          protocol_err;

  int total = 0;
  int bad = 0;
  bit checkEnable = 1'b0;

  consumer_request_port #(
    .ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .FIFO_DEPTH(DEPTH), .WAIT_CNT_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_value(in_value), .in_wr(in_wr),
    .sched_req(sched_req), .sched_res(sched_res),
    .rsp_valid(rsp_valid), .rsp_value(rsp_value), .rsp_wr(rsp_wr),
    .busy(busy), .wait_cycles(wait_cycles), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of pending requests plus the response registers.
  logic [AW+VW:0] q [$];
  bit             mPresented = 1'b0;
  bit             mRspValid = 1'b0;
  logic [VW-1:0]  mRspValue = '0;
  bit             mRspWr = 1'b0;
  int             mWait = 0;
  bit             mErr = 1'b0;
  bit             mSvc;
  bit             mAcc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      mPresented = 1'b0;
      mRspValid = 1'b0;
      mRspValue = '0;
      mRspWr = 1'b0;
      mWait = 0;
      mErr = 1'b0;
    end else begin
      mSvc = sched_res[0] && mPresented;
      mAcc = in_valid && (q.size() < DEPTH);
      if (sched_res[0] && !mPresented) mErr = 1'b1;
      mPresented = (q.size() != 0) && !sched_res[0];
      if (mSvc) begin
        mRspValid = 1'b1;
        mRspValue = sched_res[VW:1];
        mRspWr = q[0][0];
        void'(q.pop_front());
        mWait = 0;
      end else begin
        mRspValid = 1'b0;
        if (q.size() != 0) mWait = (mWait == 255) ? 255 : mWait + 1;
        else mWait = 0;
      end
      if (mAcc) q.push_back({in_addr, in_value, in_wr});
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  logic [AW+VW+1:0] expReq;
  always @(negedge clk) begin
    if (checkEnable) begin
      expReq = (!reset && q.size() != 0) ? {q[0], ~sched_res[0]} : '0;
      checkOutput("cmpSchedReq", 32'(sched_req), 32'(expReq));
      checkOutput("cmpInReady", 32'(in_ready), 32'(!reset && q.size() != DEPTH));
      checkOutput("cmpBusy", 32'(busy), 32'(q.size() != 0));
      checkOutput("cmpRspValid", 32'(rsp_valid), 32'(mRspValid));
      checkOutput("cmpRspValue", 32'(rsp_value), 32'(mRspValue));
      checkOutput("cmpRspWr", 32'(rsp_wr), 32'(mRspWr));
      checkOutput("cmpWait", 32'(wait_cycles), 32'(mWait));
      checkOutput("cmpErr", 32'(protocol_err), 32'(mErr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [VW-1:0] value, input logic wr);
    in_valid = 1'b1;
    in_addr = addr;
    in_value = value;
    in_wr = wr;
    tick();
    in_valid = 1'b0;
  endtask

  // Scheduler issues in the current presented cycle and answers one cycle later.
  task automatic respond(input logic [VW-1:0] data);
    tick();
    sched_res = {data, 1'b1};
    #1;
    checkOutput("maskInResponse", 32'(sched_req[0]), 32'h0);
    tick();
    sched_res = '0;
  endtask

  task automatic serve(input logic [VW-1:0] data);
    int n = 0;
    while (!sched_req[0] && n < 20) begin
      tick();
      n++;
    end
    if (!sched_req[0]) begin
      checkOutput("presentTimeout", 32'h0, 32'h1);
    end else begin
      respond(data);
      checkOutput("servePulse", 32'(rsp_valid), 32'h1);
      checkOutput("serveValue", 32'(rsp_value), 32'(data));
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    checkEnable = 1'b1;
    checkOutput("resetInReady", 32'(in_ready), 32'h0);
    checkOutput("resetSchedReq", 32'(sched_req), 32'h0);
    checkOutput("resetBusy", 32'(busy), 32'h0);
    checkOutput("resetErr", 32'(protocol_err), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("inReadyAfterReset", 32'(in_ready), 32'h1);

    // Single read with immediate grant.
    applyStimulus(4'hA, 8'h00, 1'b0);
    checkOutput("singleSchedReq", 32'(sched_req), 32'h2801);
    respond(8'h5C);
    checkOutput("singlePulse", 32'(rsp_valid), 32'h1);
    checkOutput("singleValue", 32'(rsp_value), 32'h5C);
    checkOutput("singleWr", 32'(rsp_wr), 32'h0);
    checkOutput("singleWait", 32'(wait_cycles), 32'h0);
    tick();
    checkOutput("singlePulseEnds", 32'(rsp_valid), 32'h0);

    // Delayed grant on a write.
    applyStimulus(4'h3, 8'hF0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkOutput("delayWait", 32'(wait_cycles), 32'(k));
      checkOutput("delayReqHeld", 32'(sched_req), 32'h0FC3);
    end
    respond(8'hF0);
    checkOutput("delayPulse", 32'(rsp_valid), 32'h1);
    checkOutput("delayWr", 32'(rsp_wr), 32'h1);
    checkOutput("delayEmpty", 32'(busy), 32'h0);

    // Fill the FIFO, offer a fifth, then drain in order.
    for (int i = 0; i < 4; i++) applyStimulus(AW'(i + 1), VW'(8'h20 + i), 1'(i));
    checkOutput("fullInReady", 32'(in_ready), 32'h0);
    applyStimulus(4'hE, 8'hEE, 1'b1);
    serve(8'h10);
    checkOutput("freedInReady", 32'(in_ready), 32'h1);
    serve(8'h11);
    serve(8'h12);
    serve(8'h13);
    checkOutput("drainBusy", 32'(busy), 32'h0);

    // Ten enqueue/service pairs wrap the pointers.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(AW'(i), VW'(i * 17), 1'(i));
      serve(VW'(8'hA0 + i));
    end

    // Hold a grant off long enough to saturate the wait counter.
    applyStimulus(4'h7, 8'h00, 1'b0);
    repeat (300) tick();
    checkOutput("saturatedWait", 32'(wait_cycles), 32'd255);
    checkOutput("saturatedReq", 32'(sched_req), 32'h1C01);
    serve(8'h77);
    tick();

    // Stray response with an empty FIFO.
    sched_res = {8'h99, 1'b1};
    tick();
    sched_res = '0;
    checkOutput("strayErr", 32'(protocol_err), 32'h1);
    checkOutput("strayNoPulse", 32'(rsp_valid), 32'h0);
    repeat (3) tick();
    checkOutput("strayErrHeld", 32'(protocol_err), 32'h1);

    // Reset with two queued entries discards them.
    applyStimulus(4'h5, 8'h55, 1'b0);
    applyStimulus(4'h6, 8'h66, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midResetErr", 32'(protocol_err), 32'h0);
    checkOutput("midResetBusy", 32'(busy), 32'h0);
    checkOutput("midResetInReady", 32'(in_ready), 32'h0);
    tick();
    reset = 1'b0;
    sched_res = {8'h42, 1'b1};
    tick();
    sched_res = '0;
    checkOutput("postResetErr", 32'(protocol_err), 32'h1);
    checkOutput("postResetNoPulse", 32'(rsp_valid), 32'h0);
    repeat (4) tick();
    checkOutput("postResetIdle", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
